frame_swap_controller: RTL

Sequences the double-buffered frame store. Each frame, it optionally clears the back buffer, then hands port b to the renderer. It waits for the renderer to finish, then issues the one-cycle `switch_buffer` pulse on the next vertical-blank start, so the display never shows a half-drawn frame. It sits between the display timing generator, the renderer, and the buffer mux's port b and `switch_buffer` inputs.

---
 rtl/frame_swap_controller_pkg.sv | 27 ++
 rtl/frame_swap_controller_fb_clear_sweeper.sv | 76 +++++++
 rtl/frame_swap_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/frame_swap_controller_pkg.sv
// Shared definitions for the double-buffered frame store control path.
//   pixel_t       : one frame-buffer pixel (RGB565)
//   FB_X_BITS     : width of the raster x counter
//   FB_Y_BITS     : width of the raster y counter
//   swap_state_t  : frame sequencing states
//   sat_inc16     : 16-bit increment that sticks at all-ones
package common;

    typedef logic [15:0] pixel_t;

    localparam int FB_X_BITS = 10;
    localparam int FB_Y_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CLEAR       = 3'd1,
        ST_GRANT       = 3'd2,
        ST_RENDER      = 3'd3,
        ST_WAIT_VBLANK = 3'd4,
        ST_SWAP        = 3'd5
    } swap_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_swap_controller_fb_clear_sweeper.sv
// Raster counter used to blank the back buffer, one pixel per clock.
// A start pulse arms the sweep at (0,0); x runs 0..H_ACTIVE-1, then wraps
// and y advances. done is high during the final pixel (H_ACTIVE-1,
// V_ACTIVE-1), after which the sweeper idles with we low.
// Ports:
//   clock, reset : clock and asynchronous active-low reset
//   start        : one-cycle pulse, begins a sweep from (0,0)
//   done         : high while the last pixel is being written
//   x, y         : registered pixel address
//   we           : registered write enable (high for the whole sweep)
module fb_clear_sweeper
    import common::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 done,
    output logic [FB_X_BITS-1:0] x,
    output logic [FB_Y_BITS-1:0] y,
    output logic                 we
);

    localparam logic [FB_X_BITS-1:0] X_LAST = FB_X_BITS'(H_ACTIVE - 1);
    localparam logic [FB_Y_BITS-1:0] Y_LAST = FB_Y_BITS'(V_ACTIVE - 1);

    logic [FB_X_BITS-1:0] x_q, x_d;
    logic [FB_Y_BITS-1:0] y_q, y_d;
    logic                 active_q, active_d;
    logic                 last_px;

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        active_d = active_q;
        if (start) begin
            x_d      = '0;
            y_d      = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d      = '0;
                    active_d = 1'b0;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q      <= '0;
            y_q      <= '0;
            active_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
        end
    end

    assign done = active_q && last_px;
    assign x    = x_q;
    assign y    = y_q;
    assign we   = active_q;

endmodule

// File: rtl/frame_swap_controller.sv
// Frame sequencer for the double-buffered frame store. Per frame it
// optionally blanks the back buffer, grants port b to the renderer, waits
// for render_done, then fires switch_buffer in the cycle after the next
// vblank_start so a half-drawn frame is never displayed.
// Build option: define BUFFER_CLEAR_EN to include the CLEAR sweep; without
// it IDLE/SWAP go straight to GRANT and the back buffer is not blanked.
// Ports:
//   clock, reset              : clock, asynchronous active-low reset
//   run                       : keep sequencing frames while high
//   vblank_start              : pulse at the first blank line
//   frame_start               : pulse, port b granted to renderer
//   render_done               : pulse, renderer finished the frame
//   r_x, r_y, r_we, r_wdata   : renderer port-b request
//   b_x, b_y, b_we, b_wdata   : port b towards the buffer mux
//   switch_buffer             : one-cycle swap pulse
//   busy                      : high outside IDLE
//   frame_count               : completed swaps (wrapping)
//   dropped_count             : vblanks missed while not ready (saturating)
//
// state        | meaning
// -------------+-----------------------------------------------
// IDLE         | not sequencing, port b isolated
// CLEAR        | sweeping CLEAR_COLOR over the back buffer
// GRANT        | frame_start pulse, renderer owns port b next
// RENDER       | r_* routed to b_*, waiting for render_done
// WAIT_VBLANK  | frame ready, holding for the next vblank
// SWAP         | switch_buffer pulse, frame_count advances
module frame_swap_controller
    import common::*;
#(
    parameter int     H_ACTIVE    = 640,
    parameter int     V_ACTIVE    = 480,
    parameter pixel_t CLEAR_COLOR = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        vblank_start,
    output logic        frame_start,
    input  logic        render_done,
    input  logic [9:0]  r_x,
    input  logic [9:0]  r_y,
    input  logic        r_we,
    input  pixel_t      r_wdata,
    output logic [9:0]  b_x,
    output logic [9:0]  b_y,
    output logic        b_we,
    output pixel_t      b_wdata,
    output logic        switch_buffer,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [15:0] dropped_count
);

    if (H_ACTIVE < 1 || H_ACTIVE > 1024 || V_ACTIVE < 1 || V_ACTIVE > 512) begin : g_bad_geometry
        $error("frame_swap_controller: unsupported H_ACTIVE/V_ACTIVE");
    end

`ifdef BUFFER_CLEAR_EN
    localparam swap_state_t FRAME_ENTRY = ST_CLEAR;
`else
    localparam swap_state_t FRAME_ENTRY = ST_GRANT;
`endif

    swap_state_t state_q, state_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [15:0] dropped_count_q, dropped_count_d;

    logic                 clr_done;
    logic [FB_X_BITS-1:0] clr_x;
    logic [FB_Y_BITS-1:0] clr_y;
    logic                 clr_we;

`ifdef BUFFER_CLEAR_EN
    logic clr_start;

    // Arm the sweep on the transition into CLEAR so its first registered
    // pixel (0,0) is presented in the first CLEAR cycle.
    assign clr_start = (state_q != ST_CLEAR) && (state_d == ST_CLEAR);

    fb_clear_sweeper #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_sweeper (
        .clock (clock),
        .reset (reset),
        .start (clr_start),
        .done  (clr_done),
        .x     (clr_x),
        .y     (clr_y),
        .we    (clr_we)
    );
`else
    assign clr_done = 1'b0;
    assign clr_x    = '0;
    assign clr_y    = '0;
    assign clr_we   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (run) state_d = FRAME_ENTRY;
            ST_CLEAR:       if (clr_done) state_d = ST_GRANT;
            ST_GRANT:       state_d = ST_RENDER;
            ST_RENDER:      if (render_done) state_d = ST_WAIT_VBLANK;
            ST_WAIT_VBLANK: if (vblank_start) state_d = ST_SWAP;
            ST_SWAP:        state_d = run ? FRAME_ENTRY : ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_start   = 1'b0;
        switch_buffer = 1'b0;
        busy          = (state_q != ST_IDLE);
        b_x           = '0;
        b_y           = '0;
        b_we          = 1'b0;
        b_wdata       = '0;
        case (state_q)
            ST_CLEAR: begin
                b_x     = clr_x;
                b_y     = 10'(clr_y);
                b_we    = clr_we;
                b_wdata = CLEAR_COLOR;
            end
            ST_GRANT:  frame_start = 1'b1;
            ST_RENDER: begin
                b_x     = r_x;
                b_y     = r_y;
                b_we    = r_we;
                b_wdata = r_wdata;
            end
            ST_SWAP:   switch_buffer = 1'b1;
            default:   ;
        endcase
    end

    // A vblank that arrives before the frame is ready is a missed swap
    // opportunity, including one coincident with render_done.
    always_comb begin
        frame_count_d   = frame_count_q;
        dropped_count_d = dropped_count_q;
        if (state_q == ST_SWAP) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        if (vblank_start && (state_q == ST_CLEAR || state_q == ST_GRANT || state_q == ST_RENDER)) begin
            dropped_count_d = sat_inc16(dropped_count_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_count_q   <= '0;
            dropped_count_q <= '0;
        end else begin
            frame_count_q   <= frame_count_d;
            dropped_count_q <= dropped_count_d;
        end
    end

    assign frame_count   = frame_count_q;
    assign dropped_count = dropped_count_q;

endmodule
